// File: rtl/rv_pack.sv
// rv_pack: packs N consecutive WD-bit valid/ready beats into one N*WD-bit word.
// Beat 0 of a group lands in the LSBs. The output word sits in a registered
// valid/ready slot that can reload in the same cycle it drains, so there are
// no bubbles at full rate.
// Optional feature macro: RV_PACK_LAST_EN adds datain_last/dataout_keep so a
// packet can close a partial word early (unfilled slots read as zero).
module rv_pack #(
  parameter int unsigned WD = 4,
  parameter int unsigned N  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [WD-1:0]     datain,
  input  logic              datain_val,
  output logic              datain_rdy,
`ifdef RV_PACK_LAST_EN
  input  logic              datain_last,
  output logic [N-1:0]      dataout_keep,
`endif
  output logic [N*WD-1:0]   dataout,
  output logic              dataout_val,
  input  logic              dataout_rdy
);

  localparam int unsigned   CW      = $clog2(N);
  localparam logic [CW-1:0] CntLast = CW'(N - 1);

  logic [CW-1:0]       cnt_q, cnt_d;
  logic [(N-1)*WD-1:0] acc_q, acc_d;
  logic [N*WD-1:0]     dataout_q, dataout_d;
  logic                val_q, val_d;

  logic                is_final;
  logic                in_fire;
  logic                out_fire;
  logic                close;
  logic [N*WD-1:0]     acc_ext;
  logic [N*WD-1:0]     word;

  // A beat is final when it fills the last slot (or, with packets, carries last).
`ifdef RV_PACK_LAST_EN
  assign is_final = (cnt_q == CntLast) || (datain_val && datain_last);
`else
  assign is_final = (cnt_q == CntLast);
`endif

  // Only a final beat needs room in the output slot; it may take it as it drains.
  assign datain_rdy = !is_final || !val_q || dataout_rdy;
  assign in_fire    = datain_val && datain_rdy;
  assign out_fire   = val_q && dataout_rdy;
  assign close      = in_fire && is_final;

  // Pad acc by one slot so every beat index has a constant, in-range select.
  assign acc_ext = {{WD{1'b0}}, acc_q};

  // Assemble the closing word: held beats below cnt, the live beat at cnt, zeros above.
  always_comb begin
    word = '0;
    for (int unsigned k = 0; k < N; k++) begin
      if (CW'(k) < cnt_q) begin
        word[k*WD +: WD] = acc_ext[k*WD +: WD];
      end else if (CW'(k) == cnt_q) begin
        word[k*WD +: WD] = datain;
      end
    end
  end

`ifdef RV_PACK_LAST_EN
  logic [N-1:0] keep_q, keep_d;
  logic [N-1:0] keep_word;

  // Keep mask covers slots 0..cnt of the closing word.
  always_comb begin
    keep_word = '0;
    for (int unsigned k = 0; k < N; k++) begin
      keep_word[k] = (CW'(k) <= cnt_q);
    end
  end

  // Keep mask loads alongside the word it describes.
  always_comb begin
    keep_d = keep_q;
    if (close) begin
      keep_d = keep_word;
    end
  end

  // Keep mask register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      keep_q <= '0;
    end else begin
      keep_q <= keep_d;
    end
  end

  assign dataout_keep = keep_q;
`endif

  // Next-state: beat counter, accumulator and output slot.
  always_comb begin
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    dataout_d = dataout_q;
    val_d     = val_q;

    if (in_fire) begin
      if (is_final) begin
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q + CW'(1);
        for (int unsigned k = 0; k < N - 1; k++) begin
          if (CW'(k) == cnt_q) begin
            acc_d[k*WD +: WD] = datain;
          end
        end
      end
    end

    // A new word wins over a drain so back-to-back words keep valid high.
    if (close) begin
      dataout_d = word;
      val_d     = 1'b1;
    end else if (out_fire) begin
      val_d = 1'b0;
    end
  end

  // State registers; reset discards any partial group.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q     <= '0;
      acc_q     <= '0;
      dataout_q <= '0;
      val_q     <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      dataout_q <= dataout_d;
      val_q     <= val_d;
    end
  end

  assign dataout     = dataout_q;
  assign dataout_val = val_q;

endmodule

// File: tb/tb_rv_pack.sv
// Self-checking bench for rv_pack: directed scenarios plus randomized
// valid/ready traffic scored against a beat-list / word-queue reference model.
module tb_rv_pack;

  localparam int unsigned WD = 4;
  localparam int unsigned N  = 4;
  localparam int unsigned W  = N * WD;
`ifdef RV_PACK_LAST_EN
  localparam bit LastEn = 1'b1;
`else
  localparam bit LastEn = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [WD-1:0] datain = '0;
  logic          datain_val = 1'b0;
  logic          datain_rdy;
  logic [W-1:0]  dataout;
  logic          dataout_val;
  logic          dataout_rdy = 1'b0;
  logic          last_in = 1'b0;
`ifdef RV_PACK_LAST_EN
  logic [N-1:0]  dataout_keep;
`endif

  always #5 clk = ~clk;

  rv_pack #(.WD(WD), .N(N)) dut (
    .clk         (clk),
    .rst         (rst),
    .datain      (datain),
    .datain_val  (datain_val),
    .datain_rdy  (datain_rdy),
`ifdef RV_PACK_LAST_EN
    .datain_last (last_in),
    .dataout_keep(dataout_keep),
`endif
    .dataout     (dataout),
    .dataout_val (dataout_val),
    .dataout_rdy (dataout_rdy)
  );

  int n_vec = 0;
  int n_err = 0;
  int n_acc = 0;

  // Reference model: beats of the group in progress, and words awaiting output.
  logic [WD-1:0] beats[$];
  logic [W-1:0]  exp_words[$];
  logic [N-1:0]  exp_keeps[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Called at the negedge: compare DUT against model, then apply this cycle's transfers.
  task automatic model_cycle();
    bit            fin;
    bit            exp_rdy;
    logic [W-1:0]  w;
    logic [N-1:0]  kp;
    fin     = (beats.size() == N - 1) || (LastEn && datain_val && last_in);
    exp_rdy = !fin || (exp_words.size() == 0) || dataout_rdy;
    check("in_ready", 64'(datain_rdy), 64'(exp_rdy));
    check("out_valid", 64'(dataout_val), 64'(exp_words.size() != 0));
    if (exp_words.size() != 0) begin
      check("out_data", 64'(dataout), 64'(exp_words[0]));
`ifdef RV_PACK_LAST_EN
      check("out_keep", 64'(dataout_keep), 64'(exp_keeps[0]));
`endif
      if (dataout_rdy) begin
        void'(exp_words.pop_front());
        void'(exp_keeps.pop_front());
      end
    end
    if (datain_val && exp_rdy) begin
      n_acc++;
      beats.push_back(datain);
      if (beats.size() == N || (LastEn && last_in)) begin
        w = '0;
        for (int i = 0; i < beats.size(); i++) begin
          w = w | (W'(beats[i]) << (i * WD));
        end
        kp = N'((1 << beats.size()) - 1);
        exp_words.push_back(w);
        exp_keeps.push_back(kp);
        beats.delete();
      end
    end
  endtask

  task automatic cycle(input logic v, input logic [WD-1:0] d, input logic r, input logic l);
    datain_val  = v;
    datain      = d;
    dataout_rdy = r;
    last_in     = l;
    @(negedge clk);
    model_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, '0, 1'b1, 1'b0);
  endtask

  initial begin
    // Reset state while held in reset.
    #3;
    check("rst_val", 64'(dataout_val), 64'(0));
    check("rst_data", 64'(dataout), 64'(0));
    check("rst_rdy", 64'(datain_rdy), 64'(1));
    @(posedge clk);
    #1;
    rst = 1'b1;

    // Single group at full rate.
    for (int i = 1; i <= 4; i++) cycle(1'b1, WD'(i), 1'b1, 1'b0);
    check("first_word", 64'(dataout), 64'(16'h4321));
    check("first_val", 64'(dataout_val), 64'(1));
    idle(2);

    // Eight beats back to back.
    for (int i = 1; i <= 8; i++) cycle(1'b1, WD'(i), 1'b1, 1'b0);
    idle(2);

    // Backpressure: word pending, three beats absorbed, fourth held off.
    for (int i = 1; i <= 4; i++) cycle(1'b1, WD'(i), 1'b0, 1'b0);
    for (int i = 5; i <= 7; i++) cycle(1'b1, WD'(i), 1'b0, 1'b0);
    cycle(1'b1, WD'(8), 1'b0, 1'b0);
    cycle(1'b1, WD'(8), 1'b0, 1'b0);
    check("stall_word", 64'(dataout), 64'(16'h4321));
    cycle(1'b1, WD'(8), 1'b1, 1'b0);
    check("b2b_word", 64'(dataout), 64'(16'h8765));
    check("b2b_val", 64'(dataout_val), 64'(1));
    idle(2);

    // Asynchronous reset mid-group with a word pending.
    for (int i = 1; i <= 4; i++) cycle(1'b1, WD'(i), 1'b0, 1'b0);
    cycle(1'b1, WD'(14), 1'b0, 1'b0);
    cycle(1'b1, WD'(15), 1'b0, 1'b0);
    #2;
    rst = 1'b0;
    #1;
    check("arst_val", 64'(dataout_val), 64'(0));
    check("arst_data", 64'(dataout), 64'(0));
    beats.delete();
    exp_words.delete();
    exp_keeps.delete();
    @(posedge clk);
    #1;
    rst = 1'b1;
    cycle(1'b1, WD'(9), 1'b1, 1'b0);
    cycle(1'b1, WD'(10), 1'b1, 1'b0);
    cycle(1'b1, WD'(11), 1'b1, 1'b0);
    cycle(1'b1, WD'(12), 1'b1, 1'b0);
    check("post_rst_word", 64'(dataout), 64'(16'hCBA9));
    idle(2);

`ifdef RV_PACK_LAST_EN
    // Short packet closes early, then a full group.
    cycle(1'b1, WD'(1), 1'b1, 1'b0);
    cycle(1'b1, WD'(2), 1'b1, 1'b1);
    check("last_word", 64'(dataout), 64'(16'h0021));
    check("last_keep", 64'(dataout_keep), 64'(4'b0011));
    for (int i = 1; i <= 4; i++) cycle(1'b1, WD'(i), 1'b1, 1'b0);
    check("full_keep", 64'(dataout_keep), 64'(4'b1111));
    idle(2);
`endif

    // Random traffic, bounded by a cycle budget.
    n_acc = 0;
    for (int c = 0; c < 20000 && n_acc < 1000; c++) begin
      cycle($urandom_range(0, 3) != 0, WD'($urandom), $urandom_range(0, 2) != 0,
            LastEn && ($urandom_range(0, 7) == 0));
    end
    check("beat_budget", 64'(n_acc >= 1000), 64'(1));
    idle(3);
    check("drained", 64'(exp_words.size()), 64'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
